// File: rtl/tluh_pkg.sv
// TL-UH shared types, bus widths and the burst beat-count helper.
package tluh_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int unsigned TL_DBW_LOG2 = $clog2(TL_DBW);
  localparam int TL_SZW = 3;
  localparam int TL_AIW = 2;
  localparam int TL_BEATSMAXW = (1 << TL_SZW) - TL_DBW_LOG2;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2
  } tl_d_op_e;

  typedef enum logic [2:0] {
    ArMin  = 3'd0,
    ArMax  = 3'd1,
    ArMinu = 3'd2,
    ArMaxu = 3'd3,
    ArAdd  = 3'd4
  } tl_arith_e;

  typedef enum logic [2:0] {
    LgXor  = 3'd0,
    LgOr   = 3'd1,
    LgAnd  = 3'd2,
    LgSwap = 3'd3
  } tl_logic_e;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tluh_d2h_t;

  function automatic logic [TL_BEATSMAXW-1:0] tl_beats(
    input logic [TL_SZW-1:0] size,
    input int unsigned       max_size
  );
    int unsigned sz;
    sz = 32'(size);
    if (sz > max_size) sz = max_size;
    if (sz <= TL_DBW_LOG2) return TL_BEATSMAXW'(1);
    return TL_BEATSMAXW'(1 << (sz - TL_DBW_LOG2));
  endfunction
endpackage

// File: rtl/tluh_host_adapter_mo_tracker.sv
// Source-ID pool: free bitmap, lowest-free pick, per-ID D beat counters.
module tluh_src_tracker
  import tluh_pkg::*;
#(
  parameter int MAX_REQS = 4,
  localparam int OCW = $clog2(MAX_REQS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_i,
  input  logic [TL_BEATSMAXW-1:0] alloc_beats_i,
  input  logic                    d_valid_i,
  input  logic [TL_AIW-1:0]       d_source_i,
  output logic                    any_free_o,
  output logic [TL_AIW-1:0]       alloc_id_o,
  output logic                    last_o,
  output logic                    src_busy_o,
  output logic [OCW-1:0]          outstanding_o
);
  logic [MAX_REQS-1:0] free_q, free_d;
  logic [MAX_REQS-1:0][TL_BEATSMAXW-1:0] cnt_q, cnt_d;

  always_comb begin
    any_free_o = |free_q;
    alloc_id_o = '0;
    outstanding_o = '0;
    for (int i = MAX_REQS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_id_o = TL_AIW'(i);
      else outstanding_o = outstanding_o + OCW'(1);
    end
  end

  always_comb begin
    src_busy_o = 1'b0;
    for (int i = 0; i < MAX_REQS; i++) begin
      if (d_source_i == TL_AIW'(i)) src_busy_o = ~free_q[i];
    end
  end

  // A free ID keeps a zero count, so stray beats never underflow it.
  always_comb begin
    free_d = free_q;
    cnt_d = cnt_q;
    last_o = 1'b0;
    for (int i = 0; i < MAX_REQS; i++) begin
      if (d_valid_i && d_source_i == TL_AIW'(i) && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - TL_BEATSMAXW'(1);
        if (cnt_q[i] == TL_BEATSMAXW'(1)) begin
          last_o = 1'b1;
          free_d[i] = 1'b1;
        end
      end
      if (alloc_i && alloc_id_o == TL_AIW'(i)) begin
        free_d[i] = 1'b0;
        cnt_d[i] = alloc_beats_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q <= '1;
      cnt_q <= '0;
    end else begin
      free_q <= free_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tluh_host_adapter_mo.sv
// Multi-outstanding burst TL-UH host adapter: A-burst FSM plus A/D mapping.
// Define TLUH_HOST_SRC_CHECK_EN to drop D beats for IDs not in flight.
module tluh_host_adapter_mo
  import tluh_pkg::*;
#(
  parameter int MAX_REQS = 4,
  parameter int MAX_SIZE = 4,
  localparam int OCW = $clog2(MAX_REQS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [TL_SZW-1:0] size_i,
  input  logic              we_i,
  input  logic              atomic_i,
  input  logic              arith_i,
  input  logic              intent_i,
  input  logic [2:0]        param_i,
  input  logic [TL_AW-1:0]  addr_i,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] be_i,
  output logic              valid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              err_o,
  output logic [TL_AIW-1:0] rsp_src_o,
  output logic              rsp_last_o,
  output logic [TL_AIW-1:0] req_src_o,
  output logic [OCW-1:0]    outstanding_o,
  output tluh_h2d_t         tl_h_c_a,
  input  tluh_d2h_t         tl_h_c_d
);
  typedef enum logic {S_IDLE, S_BURST} st_e;

  st_e                     state_q, state_d;
  logic [TL_BEATSMAXW-1:0] rem_q, rem_d;
  logic [TL_AIW-1:0]       src_q, src_d;
  tl_a_op_e                op_q, op_d;
  logic [TL_SZW-1:0]       size_q, size_d;
  logic [TL_AW-1:0]        addr_q, addr_d;
  logic [2:0]              param_q, param_d;

  logic idle, any_free, xfer, alloc, last, src_busy;
  logic stray, err_pls;
  logic [TL_AIW-1:0] alloc_id, cur_src, err_src;
  logic [TL_AW-1:0] cur_addr;
  tl_a_op_e op_new, cur_op;
  logic [TL_BEATSMAXW-1:0] nb, a_beats, d_beats;

  tluh_src_tracker #(.MAX_REQS(MAX_REQS)) u_trk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alloc_i      (alloc),
    .alloc_beats_i(d_beats),
    .d_valid_i    (valid_o),
    .d_source_i   (tl_h_c_d.d_source),
    .any_free_o   (any_free),
    .alloc_id_o   (alloc_id),
    .last_o       (last),
    .src_busy_o   (src_busy),
    .outstanding_o(outstanding_o)
  );

  always_comb begin
    op_new = PutPartialData;
    priority case (1'b1)
      atomic_i && arith_i: op_new = ArithmeticData;
      atomic_i:            op_new = LogicalData;
      intent_i:            op_new = Intent;
      !we_i:               op_new = Get;
      &be_i:               op_new = PutFullData;
      default:             op_new = PutPartialData;
    endcase
  end

  always_comb begin
    idle = state_q == S_IDLE;
    nb = tl_beats(size_i, MAX_SIZE);
    a_beats = (op_new inside {Get, Intent}) ? TL_BEATSMAXW'(1) : nb;
    d_beats = (op_new inside {Get, ArithmeticData, LogicalData})
              ? nb : TL_BEATSMAXW'(1);
    gnt_o = rst_ni & tl_h_c_d.a_ready & (~idle | any_free);
    xfer = req_i & gnt_o;
    alloc = xfer & idle;
    cur_src = idle ? alloc_id : src_q;
    cur_op = idle ? op_new : op_q;
    cur_addr = idle ? addr_i : addr_q;
    req_src_o = cur_src;

    tl_h_c_a = '0;
    tl_h_c_a.a_valid = rst_ni & req_i & (~idle | any_free);
    tl_h_c_a.a_opcode = cur_op;
    if (cur_op inside {ArithmeticData, LogicalData, Intent})
      tl_h_c_a.a_param = idle ? param_i : param_q;
    tl_h_c_a.a_size = idle ? size_i : size_q;
    tl_h_c_a.a_source = cur_src;
    tl_h_c_a.a_address = {cur_addr[TL_AW-1:2], 2'b00};
    tl_h_c_a.a_mask = (cur_op == Get) ? '1 : be_i;
    tl_h_c_a.a_data = wdata_i;
    tl_h_c_a.d_ready = 1'b1;

    state_d = state_q;
    rem_d = rem_q;
    src_d = src_q;
    op_d = op_q;
    size_d = size_q;
    addr_d = addr_q;
    param_d = param_q;
    if (alloc) begin
      src_d = alloc_id;
      op_d = op_new;
      size_d = size_i;
      addr_d = addr_i;
      param_d = param_i;
      if (a_beats > TL_BEATSMAXW'(1)) begin
        state_d = S_BURST;
        rem_d = a_beats - TL_BEATSMAXW'(1);
      end
    end else if (xfer) begin
      rem_d = rem_q - TL_BEATSMAXW'(1);
      if (rem_q == TL_BEATSMAXW'(1)) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q <= '0;
      src_q <= '0;
      op_q <= Get;
      size_q <= '0;
      addr_q <= '0;
      param_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      src_q <= src_d;
      op_q <= op_d;
      size_q <= size_d;
      addr_q <= addr_d;
      param_q <= param_d;
    end
  end

`ifdef TLUH_HOST_SRC_CHECK_EN
  logic err_q, err_d;
  logic [TL_AIW-1:0] esrc_q, esrc_d;

  assign stray = tl_h_c_d.d_valid & ~src_busy;

  always_comb begin
    err_d = stray;
    esrc_d = stray ? tl_h_c_d.d_source : esrc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      esrc_q <= '0;
    end else begin
      err_q <= err_d;
      esrc_q <= esrc_d;
    end
  end

  assign err_pls = err_q;
  assign err_src = esrc_q;
`else
  logic unused_busy;
  assign unused_busy = src_busy;
  assign stray = 1'b0;
  assign err_pls = 1'b0;
  assign err_src = '0;
`endif

  assign valid_o = rst_ni & tl_h_c_d.d_valid & ~stray;
  assign rdata_o = tl_h_c_d.d_data;
  assign err_o = (valid_o & tl_h_c_d.d_error) | err_pls;
  assign rsp_src_o = err_pls ? err_src : tl_h_c_d.d_source;
  assign rsp_last_o = valid_o & last;

  logic unused_d;
  assign unused_d = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param,
                      tl_h_c_d.d_size, cur_addr[1:0]};
endmodule

// File: tb/tb_tluh_host_adapter_mo.sv
// Self-checking bench for tluh_host_adapter_mo: directed scenarios plus
// randomized traffic against a transaction-level model of the adapter.
module tb_tluh_host_adapter_mo;
  import tluh_pkg::*;

  localparam int MAX_REQS = 4;
  localparam int MAX_SIZE = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic req_i, gnt_o, we_i, atomic_i, arith_i, intent_i;
  logic [TL_SZW-1:0] size_i;
  logic [2:0] param_i;
  logic [TL_AW-1:0] addr_i;
  logic [TL_DW-1:0] wdata_i, rdata_o;
  logic [TL_DBW-1:0] be_i;
  logic valid_o, err_o, rsp_last_o;
  logic [TL_AIW-1:0] rsp_src_o, req_src_o;
  logic [2:0] outstanding_o;
  tluh_h2d_t tl_a;
  tluh_d2h_t tl_d;

  always #5 clk = ~clk;

  tluh_host_adapter_mo #(.MAX_REQS(MAX_REQS), .MAX_SIZE(MAX_SIZE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .size_i(size_i), .we_i(we_i), .atomic_i(atomic_i), .arith_i(arith_i),
    .intent_i(intent_i), .param_i(param_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .valid_o(valid_o), .rdata_o(rdata_o),
    .err_o(err_o), .rsp_src_o(rsp_src_o), .rsp_last_o(rsp_last_o),
    .req_src_o(req_src_o), .outstanding_o(outstanding_o),
    .tl_h_c_a(tl_a), .tl_h_c_d(tl_d)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: per-ID remaining D beats, A-burst beats left, latched burst fields.
  int m_rem[MAX_REQS];
  bit m_busy[MAX_REQS];
  int m_left, m_src, m_op, m_size, m_param;
  logic [31:0] m_addr;
  bit m_pend;
  int m_psrc;

  function automatic int beats(input int size);
    int s, b;
    s = (size > MAX_SIZE) ? MAX_SIZE : size;
    b = (1 << s) / TL_DBW;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int op_of(input bit we, input bit at, input bit ar,
                               input bit it, input logic [3:0] be);
    if (at && ar) return 2;
    if (at) return 3;
    if (it) return 5;
    if (!we) return 4;
    if (be == 4'hF) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAX_REQS; i++) begin
      m_rem[i] = 0;
      m_busy[i] = 0;
    end
    m_left = 0; m_src = 0; m_op = 4; m_size = 0; m_param = 0;
    m_addr = '0; m_pend = 0; m_psrc = 0;
  endtask

  task automatic model_step();
    int lo, n, eop, esrc, esz, epar, ds, psrc_n;
    bit anyf, idle, eg, xf, pend_n;
    logic [31:0] ead;
    lo = -1;
    n = 0;
    for (int i = MAX_REQS - 1; i >= 0; i--) if (!m_busy[i]) lo = i;
    for (int i = 0; i < MAX_REQS; i++) if (m_busy[i]) n++;
    anyf = (lo >= 0);
    idle = (m_left == 0);
    if (!rst_ni) begin
      check("rst_gnt", gnt_o, 0);
      check("rst_aval", tl_a.a_valid, 0);
      check("rst_valid", valid_o, 0);
      check("rst_last", rsp_last_o, 0);
      check("rst_outs", outstanding_o, 0);
      model_reset();
      return;
    end
    check("outs", outstanding_o, n);
    eg = tl_d.a_ready && (!idle || anyf);
    check("gnt", gnt_o, eg);
    check("a_valid", tl_a.a_valid, req_i && (!idle || anyf));
    xf = req_i && eg;
    if (idle) begin
      eop = op_of(we_i, atomic_i, arith_i, intent_i, be_i);
      esrc = lo; esz = size_i; ead = addr_i; epar = param_i;
    end else begin
      eop = m_op; esrc = m_src; esz = m_size; ead = m_addr; epar = m_param;
    end
    if (xf) begin
      check("a_src", tl_a.a_source, esrc);
      check("req_src", req_src_o, esrc);
      check("a_op", tl_a.a_opcode, eop);
      check("a_addr", tl_a.a_address, ead & ~32'h3);
      check("a_size", tl_a.a_size, esz);
      check("a_mask", tl_a.a_mask, (eop == 4) ? 4'hF : be_i);
      check("a_param", tl_a.a_param,
            (eop == 2 || eop == 3 || eop == 5) ? epar : 0);
    end
    pend_n = 0;
    psrc_n = 0;
    ds = tl_d.d_source;
    if (tl_d.d_valid) begin
      if (!m_busy[ds]) begin
`ifdef TLUH_HOST_SRC_CHECK_EN
        check("stray_valid", valid_o, 0);
        pend_n = 1;
        psrc_n = ds;
`else
        check("stray_valid", valid_o, 1);
        check("stray_last", rsp_last_o, 0);
        check("stray_err", err_o, tl_d.d_error);
`endif
      end else begin
        check("d_valid", valid_o, 1);
        check("d_data", rdata_o, tl_d.d_data);
        check("d_last", rsp_last_o, m_rem[ds] == 1);
        check("d_src", rsp_src_o, m_pend ? m_psrc : ds);
        check("d_err", err_o, tl_d.d_error || m_pend);
        m_rem[ds]--;
        if (m_rem[ds] == 0) m_busy[ds] = 0;
      end
    end else begin
      check("nod_valid", valid_o, 0);
      check("nod_last", rsp_last_o, 0);
      check("nod_err", err_o, m_pend);
      if (m_pend) check("pend_src", rsp_src_o, m_psrc);
    end
    if (xf) begin
      if (idle) begin
        m_busy[esrc] = 1;
        m_rem[esrc] = (eop inside {2, 3, 4}) ? beats(esz) : 1;
        m_left = (eop inside {0, 1, 2, 3}) ? beats(esz) - 1 : 0;
        m_src = esrc; m_op = eop; m_size = esz; m_addr = ead;
        m_param = epar;
      end else begin
        m_left--;
      end
    end
    m_pend = pend_n;
    m_psrc = psrc_n;
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit r, input bit we, input bit at, input bit ar,
                       input bit it, input int sz, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    req_i = r; we_i = we; atomic_i = at; arith_i = ar; intent_i = it;
    size_i = TL_SZW'(sz); addr_i = a; be_i = be; wdata_i = wd;
    param_i = 3'($urandom_range(0, 7));
  endtask

  task automatic set_d(input bit v, input int src, input logic [31:0] data,
                       input bit e);
    tl_d.d_valid = v;
    tl_d.d_source = TL_AIW'(src);
    tl_d.d_data = data;
    tl_d.d_error = e;
    tl_d.d_opcode = 3'd1;
  endtask

  task automatic nop();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_d(0, 0, 0, 0);
  endtask

  initial begin
    int cand[$];
    tl_d = '0;
    tl_d.a_ready = 1'b1;
    model_reset();
    nop();
    rst_ni = 1'b0;
    req_i = 1'b1;
    repeat (2) step();
    rst_ni = 1'b1;
    nop();
    step();

    set_a(1, 0, 0, 0, 0, 2, 32'h100, 4'hF, 0);
    #1;
    check("get_src0", tl_a.a_source, 0);
    check("get_op", tl_a.a_opcode, 4);
    step();
    nop();
    check("get_outs1", outstanding_o, 1);
    set_d(1, 0, 32'hDEADBEEF, 0);
    #1;
    check("get_rdata", rdata_o, 32'hDEADBEEF);
    check("get_last", rsp_last_o, 1);
    step();
    nop();
    check("get_outs0", outstanding_o, 0);

    for (int k = 0; k < 4; k++) begin
      set_a(1, 1, 0, 0, 0, 4, 32'h200 + 32'(4 * k), 4'hF, 32'(k));
      #1;
      check("bpf_gnt", gnt_o, 1);
      check("bpf_addr", tl_a.a_address, 32'h200);
      check("bpf_src", tl_a.a_source, 0);
      check("bpf_op", tl_a.a_opcode, 0);
      step();
    end
    nop();
    set_d(1, 0, 0, 0);
    #1;
    check("bpf_last", rsp_last_o, 1);
    step();
    nop();

    for (int k = 0; k < 4; k++) begin
      set_a(1, 0, 0, 0, 0, 2, 32'h300 + 32'(4 * k), 4'hF, 0);
      #1;
      check("fill_src", tl_a.a_source, k);
      step();
    end
    set_a(1, 0, 0, 0, 0, 2, 32'h400, 4'hF, 0);
    #1;
    check("full_gnt", gnt_o, 0);
    check("full_aval", tl_a.a_valid, 0);
    step();
    set_d(1, 2, 32'h22, 0);
    #1;
    check("rel_stall", gnt_o, 0);
    step();
    set_d(1, 0, 32'h11, 0);
    #1;
    check("rel_gnt", gnt_o, 1);
    check("rel_src2", tl_a.a_source, 2);
    check("rel_outs", outstanding_o, 3);
    step();
    nop();
    check("same_cyc_outs", outstanding_o, 3);
    for (int k = 1; k < 4; k++) begin
      set_d(1, k, 32'(k), 0);
      step();
    end
    nop();

    set_a(1, 0, 0, 0, 0, 4, 32'h500, 4'hF, 0);
    step();
    set_a(1, 0, 0, 0, 0, 4, 32'h540, 4'hF, 0);
    step();
    nop();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        set_d(1, 1 - n, 32'h1000 * n + 32'(k), 0);
        #1;
        check("ooo_last", rsp_last_o, k == 3);
        check("ooo_src", rsp_src_o, 1 - n);
        step();
      end
    end
    nop();

    for (int k = 0; k < 2; k++) begin
      set_a(1, 1, 0, 0, 0, 4, 32'h600, 4'hF, 32'(k));
      step();
    end
    set_d(1, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    check("mrst_gnt", gnt_o, 0);
    check("mrst_aval", tl_a.a_valid, 0);
    check("mrst_valid", valid_o, 0);
    check("mrst_outs", outstanding_o, 0);
    step();
    rst_ni = 1'b1;
    nop();
    set_a(1, 0, 0, 0, 0, 2, 32'h700, 4'hF, 0);
    #1;
    check("post_rst_op", tl_a.a_opcode, 4);
    check("post_rst_src", tl_a.a_source, 0);
    step();
    nop();
    set_d(1, 0, 32'h7, 0);
    step();
    nop();

    set_d(1, 3, 32'h55, 0);
    step();
    nop();
`ifdef TLUH_HOST_SRC_CHECK_EN
    check("stray_pulse", err_o, 1);
    check("stray_src3", rsp_src_o, 3);
`endif
    step();

    for (int c = 0; c < 3000; c++) begin
      tl_d.a_ready = ($urandom_range(0, 3) != 0);
      if (m_left == 0) begin
        atomic_i = ($urandom_range(0, 4) == 0);
        arith_i = atomic_i & 1'($urandom_range(0, 1));
        intent_i = ($urandom_range(0, 5) == 0);
        we_i = 1'($urandom_range(0, 1));
        size_i = TL_SZW'($urandom_range(0, 7));
        addr_i = $urandom;
        param_i = 3'($urandom_range(0, 7));
      end
      be_i = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      wdata_i = $urandom;
      req_i = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int i = 0; i < MAX_REQS; i++)
        if (m_busy[i] && !(m_left > 0 && m_src == i)) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 1) != 0)
        set_d(1, cand[$urandom_range(0, cand.size() - 1)], $urandom,
              $urandom_range(0, 7) == 0);
      else
        set_d(0, 0, 0, 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
